ex_mem_stage: RTL and testbench
===============================

# ex_mem_stage

Execute-to-memory pipeline stage sitting directly downstream of the ALU. It captures the ALU result, zero flag and the control bits travelling with the instruction into a two-entry skid buffer. It resolves conditional branches from the zero flag and presents one registered beat per cycle to the data-memory/writeback side with a valid/ready handshake. It also keeps saturating retire and taken-branch counters for debug.

## Interface
- DATA_W, 32, width of ALU result, store data and branch target
- RD_W, 5, destination register index width
- CNT_W, 16, width of debug counters
- clk  in  1  single clock, all state updates on rising edge
- reset  in  1  synchronous, active-low reset (sampled on rising clk edge)
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept a beat this cycle
- ALUResult  in  DATA_W  ALU output
- zero  in  1  ALU zero flag (ALUResult == 0)
- WriteData  in  DATA_W  store data (rs2 value)
- PCTarget  in  DATA_W  branch target address
- rd  in  RD_W  destination register
- RegWrite, MemWrite, Branch, BranchNe  in  1 each  control bits (BranchNe: 1 = bne, 0 = beq)
- ResultSrc  in  2  writeback mux select, passed through
- flush  in  1  discard all buffered and incoming beats
- out_valid  out  1  head beat valid
- out_ready  in  1  downstream accepts head beat
- out_ALUResult, out_WriteData, out_PCTarget  out  DATA_W each  head payload
- out_rd  out  RD_W; out_RegWrite, out_MemWrite  out  1; out_ResultSrc  out  2  head payload
- PCSrc  out  1  head beat is a taken branch (qualified by out_valid)
- retire_cnt  out  CNT_W  handshaken output beats, saturating
- taken_cnt  out  CNT_W  handshaken taken branches, saturating

## Operation
- Storage: head register (drives outputs) plus skid register; each holds the full payload and a taken bit.
- Capture transform: taken = Branch & (zero ^ BranchNe); stored RegWrite = RegWrite & (rd != 0). All other fields are copied unchanged.
- in_ready = ~skid_valid, driven from a register, with no combinational path from out_ready.
- Accept = in_valid & in_ready & ~flush. Pop = out_valid & out_ready.
- Next-state rules, priority top-down:
  - flush: head_valid = skid_valid = 0; incoming beat dropped; counters keep their values.
  - head empty: accepted beat goes to head.
  - Pop with skid full: head <= skid; skid is empty (in_ready was 0, so no accept).
  - Pop with skid empty: head <= accepted beat, or head_valid = 0 if no accept.
  - No pop, head full, accept: beat goes to skid.
- Beat order is strictly preserved. Payload and PCSrc hold stable while out_valid & ~out_ready.
- PCSrc = out_valid & head_taken.
- Counters: retire_cnt increments on Pop; taken_cnt increments on Pop & PCSrc. Both saturate at all-ones and do not wrap.

## Timing
- Reset (reset = 0 at a rising edge): out_valid = 0, PCSrc = 0, all out_* payload = 0, retire_cnt = taken_cnt = 0, skid empty, in_ready = 1 after that edge.
- Latency: a beat accepted at edge N into an empty stage shows out_valid = 1 after edge N; ALU-to-output latency is 1 cycle.
- Throughput: 1 beat/cycle with out_ready held high; in_ready stays 1.
- Backpressure: with out_ready = 0, the second accepted beat fills the skid and in_ready drops after that edge. It rises 1 cycle after the next Pop.
- flush while reset is inactive: stage is empty after the edge, and in_ready = 1 after the edge.
- reset asserted mid-transfer: in-flight beats are lost and there is no partial output.
- Simultaneous Pop and accept with skid empty: head is replaced in the same edge with no bubble.

## Test plan
- Reset, then ALUResult = 0x0000_0005, rd = 3, RegWrite = 1, one beat with out_ready = 1 -> out_valid = 1 one cycle later, out_ALUResult = 5, out_RegWrite = 1, retire_cnt = 1.
- beq: Branch = 1, BranchNe = 0, zero = 1, PCTarget = 0x40 -> PCSrc = 1, out_PCTarget = 0x40, taken_cnt = 1. Repeat with BranchNe = 1 -> PCSrc = 0, taken_cnt unchanged.
- rd = 0 with RegWrite = 1 -> out_RegWrite = 0.
- out_ready = 0 while sending beats A, B, C (C held) -> in_ready = 0 after B. Release out_ready -> outputs A, B, C in order with no loss or duplication.
- Beats buffered in head and skid, flush = 1 with in_valid = 1 -> out_valid = 0 next cycle, incoming beat never appears, counters unchanged.
- Preload retire_cnt near 0xFFFF via 65535+ streamed pops -> holds at 0xFFFF. Then reset = 0 for one edge -> counters and out_valid = 0.

Source files
------------

// File: rtl/ex_mem_stage_if.sv
// Handshake bundles on either side of the EX/MEM stage: the ALU-side beat
// going in and the memory/writeback-side beat coming out.
interface ex_mem_in_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] ALUResult;
  logic              zero;
  logic [DATA_W-1:0] WriteData;
  logic [DATA_W-1:0] PCTarget;
  logic [RD_W-1:0]   rd;
  logic              RegWrite;
  logic              MemWrite;
  logic              Branch;
  logic              BranchNe;
  logic [1:0]        ResultSrc;

  modport master (
    output in_valid, ALUResult, zero, WriteData, PCTarget, rd,
           RegWrite, MemWrite, Branch, BranchNe, ResultSrc,
    input  in_ready
  );

  modport slave (
    input  in_valid, ALUResult, zero, WriteData, PCTarget, rd,
           RegWrite, MemWrite, Branch, BranchNe, ResultSrc,
    output in_ready
  );
endinterface

interface ex_mem_out_if #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ALUResult;
  logic [DATA_W-1:0] out_WriteData;
  logic [DATA_W-1:0] out_PCTarget;
  logic [RD_W-1:0]   out_rd;
  logic              out_RegWrite;
  logic              out_MemWrite;
  logic [1:0]        out_ResultSrc;
  logic              PCSrc;

  modport master (
    output out_valid, out_ALUResult, out_WriteData, out_PCTarget, out_rd,
           out_RegWrite, out_MemWrite, out_ResultSrc, PCSrc,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_ALUResult, out_WriteData, out_PCTarget, out_rd,
           out_RegWrite, out_MemWrite, out_ResultSrc, PCSrc,
    output out_ready
  );
endinterface

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline stage: two-entry skid buffer (head + skid), branch resolution
// from the zero flag, and saturating debug counters for retired/taken beats.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int RD_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  ex_mem_in_if.slave       up,
  ex_mem_out_if.master     dn,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] taken_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] pc_target;
    logic [RD_W-1:0]   rd;
    logic              reg_write;
    logic              mem_write;
    logic [1:0]        result_src;
    logic              taken;
  } beat_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HEAD  = 2'd1,
    ST_FULL  = 2'd2
  } occ_t;

  occ_t  state_reg, state_next;
  beat_t head_reg, skid_reg, in_beat;
  logic  load_head_in, load_head_skid, load_skid;
  logic  accept, pop;

  // Branch resolves at capture; writes to x0 are squashed here so the
  // writeback side never has to check rd.
  always_comb begin
    in_beat            = '0;
    in_beat.alu_result = up.ALUResult;
    in_beat.write_data = up.WriteData;
    in_beat.pc_target  = up.PCTarget;
    in_beat.rd         = up.rd;
    in_beat.reg_write  = up.RegWrite & (up.rd != '0);
    in_beat.mem_write  = up.MemWrite;
    in_beat.result_src = up.ResultSrc;
    in_beat.taken      = up.Branch & (up.zero ^ up.BranchNe);
  end

  // in_ready decodes only the occupancy register, so out_ready never reaches it.
  assign up.in_ready = (state_reg != ST_FULL);
  assign dn.out_valid = (state_reg != ST_EMPTY);

  assign accept = up.in_valid & up.in_ready & ~flush;
  assign pop    = dn.out_valid & dn.out_ready;

  always_comb begin
    state_next     = state_reg;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_next = ST_EMPTY;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            load_head_in = 1'b1;
            state_next   = ST_HEAD;
          end
        end
        ST_HEAD: begin
          if (pop) begin
            if (accept) begin
              load_head_in = 1'b1;
            end else begin
              state_next = ST_EMPTY;
            end
          end else if (accept) begin
            load_skid  = 1'b1;
            state_next = ST_FULL;
          end
        end
        ST_FULL: begin
          if (pop) begin
            load_head_skid = 1'b1;
            state_next     = ST_HEAD;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= ST_EMPTY;
      head_reg  <= '0;
      skid_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (load_head_in) begin
        head_reg <= in_beat;
      end else if (load_head_skid) begin
        head_reg <= skid_reg;
      end
      if (load_skid) begin
        skid_reg <= in_beat;
      end
    end
  end

  assign dn.out_ALUResult = head_reg.alu_result;
  assign dn.out_WriteData = head_reg.write_data;
  assign dn.out_PCTarget  = head_reg.pc_target;
  assign dn.out_rd        = head_reg.rd;
  assign dn.out_RegWrite  = head_reg.reg_write;
  assign dn.out_MemWrite  = head_reg.mem_write;
  assign dn.out_ResultSrc = head_reg.result_src;
  assign dn.PCSrc         = dn.out_valid & head_reg.taken;

  // Index 0 counts retired beats, index 1 counts retired taken branches.
  logic [1:0] cnt_inc;
  assign cnt_inc = {pop & ~flush & dn.PCSrc, pop & ~flush};

  for (genvar gi = 0; gi < 2; gi++) begin : gen_cnt
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!reset) begin
        cnt_reg <= '0;
      end else if (cnt_inc[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
      end
    end
  end

  assign retire_cnt = gen_cnt[0].cnt_reg;
  assign taken_cnt  = gen_cnt[1].cnt_reg;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: reset, branch resolution, x0 squash,
// backpressure ordering, flush, counter saturation and reset recovery.
module tb_ex_mem_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [15:0] retire_cnt;
  logic [15:0] taken_cnt;
  int          checks;
  int          errors;

  ex_mem_in_if  #(.DATA_W(32), .RD_W(5)) up ();
  ex_mem_out_if #(.DATA_W(32), .RD_W(5)) dn ();

  ex_mem_stage #(.DATA_W(32), .RD_W(5), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .up         (up),
    .dn         (dn),
    .retire_cnt (retire_cnt),
    .taken_cnt  (taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    up.in_valid  = 1'b0;
    up.ALUResult = '0;
    up.zero      = 1'b0;
    up.WriteData = '0;
    up.PCTarget  = '0;
    up.rd        = '0;
    up.RegWrite  = 1'b0;
    up.MemWrite  = 1'b0;
    up.Branch    = 1'b0;
    up.BranchNe  = 1'b0;
    up.ResultSrc = 2'b00;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_in();
    flush        = 1'b0;
    dn.out_ready = 1'b0;
    reset        = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    $display("reset: out_valid=%0b in_ready=%0b retire=%0d", dn.out_valid, up.in_ready, retire_cnt);
    check("rst_out_valid", dn.out_valid, 0);
    check("rst_pcsrc", dn.PCSrc, 0);
    check("rst_alu", dn.out_ALUResult, 0);
    check("rst_retire", retire_cnt, 0);
    check("rst_taken", taken_cnt, 0);
    check("rst_in_ready", up.in_ready, 1);

    // Single ALU beat, rd = 3
    up.in_valid = 1'b1; up.ALUResult = 32'h5; up.rd = 5'd3; up.RegWrite = 1'b1;
    up.WriteData = 32'h1234; up.ResultSrc = 2'b10; dn.out_ready = 1'b1;
    tick();
    clear_in();
    $display("beat alu: valid=%0b alu=%0h rw=%0b", dn.out_valid, dn.out_ALUResult, dn.out_RegWrite);
    check("alu_valid", dn.out_valid, 1);
    check("alu_result", dn.out_ALUResult, 32'h5);
    check("alu_regwrite", dn.out_RegWrite, 1);
    check("alu_rd", dn.out_rd, 3);
    check("alu_wdata", dn.out_WriteData, 32'h1234);
    check("alu_resultsrc", dn.out_ResultSrc, 2'b10);
    tick();
    check("alu_retire", retire_cnt, 1);
    check("alu_drain", dn.out_valid, 0);

    // beq taken
    up.in_valid = 1'b1; up.Branch = 1'b1; up.BranchNe = 1'b0; up.zero = 1'b1; up.PCTarget = 32'h40;
    tick();
    clear_in();
    $display("beat beq: pcsrc=%0b target=%0h", dn.PCSrc, dn.out_PCTarget);
    check("beq_pcsrc", dn.PCSrc, 1);
    check("beq_target", dn.out_PCTarget, 32'h40);
    tick();
    check("beq_taken_cnt", taken_cnt, 1);
    check("beq_retire", retire_cnt, 2);

    // bne with zero = 1 -> not taken
    up.in_valid = 1'b1; up.Branch = 1'b1; up.BranchNe = 1'b1; up.zero = 1'b1; up.PCTarget = 32'h80;
    tick();
    clear_in();
    $display("beat bne: pcsrc=%0b", dn.PCSrc);
    check("bne_pcsrc", dn.PCSrc, 0);
    tick();
    check("bne_taken_cnt", taken_cnt, 1);
    check("bne_retire", retire_cnt, 3);

    // Write to x0 is squashed
    up.in_valid = 1'b1; up.rd = 5'd0; up.RegWrite = 1'b1; up.ALUResult = 32'h7;
    tick();
    clear_in();
    $display("beat x0: regwrite=%0b", dn.out_RegWrite);
    check("x0_regwrite", dn.out_RegWrite, 0);
    check("x0_valid", dn.out_valid, 1);
    tick();
    check("x0_retire", retire_cnt, 4);

    // Backpressure: A, B fill the buffer, C held
    dn.out_ready = 1'b0;
    up.in_valid = 1'b1; up.ALUResult = 32'hA;
    tick();
    $display("bp A: in_ready=%0b alu=%0h", up.in_ready, dn.out_ALUResult);
    check("bp_a_in_ready", up.in_ready, 1);
    check("bp_a_alu", dn.out_ALUResult, 32'hA);
    up.ALUResult = 32'hB;
    tick();
    $display("bp B: in_ready=%0b alu=%0h", up.in_ready, dn.out_ALUResult);
    check("bp_b_in_ready", up.in_ready, 0);
    check("bp_b_alu_hold", dn.out_ALUResult, 32'hA);
    up.ALUResult = 32'hC;
    tick();
    check("bp_c_in_ready", up.in_ready, 0);
    check("bp_c_alu_hold", dn.out_ALUResult, 32'hA);
    dn.out_ready = 1'b1;
    tick();
    $display("bp pop A: alu=%0h in_ready=%0b", dn.out_ALUResult, up.in_ready);
    check("bp_out_b", dn.out_ALUResult, 32'hB);
    check("bp_pop_in_ready", up.in_ready, 1);
    tick();
    up.in_valid = 1'b0;
    $display("bp pop B: alu=%0h valid=%0b", dn.out_ALUResult, dn.out_valid);
    check("bp_out_c", dn.out_ALUResult, 32'hC);
    check("bp_out_c_valid", dn.out_valid, 1);
    tick();
    check("bp_drained", dn.out_valid, 0);
    check("bp_retire", retire_cnt, 7);

    // Flush with head and skid occupied and an incoming beat
    dn.out_ready = 1'b0;
    up.in_valid = 1'b1; up.ALUResult = 32'hD;
    tick();
    up.ALUResult = 32'hE;
    tick();
    check("fl_full", up.in_ready, 0);
    up.ALUResult = 32'hF; flush = 1'b1;
    tick();
    flush = 1'b0; up.in_valid = 1'b0;
    $display("flush: valid=%0b in_ready=%0b retire=%0d", dn.out_valid, up.in_ready, retire_cnt);
    check("fl_valid", dn.out_valid, 0);
    check("fl_in_ready", up.in_ready, 1);
    check("fl_retire", retire_cnt, 7);
    check("fl_taken", taken_cnt, 1);
    dn.out_ready = 1'b1;
    tick();
    check("fl_no_ghost", dn.out_valid, 0);

    // Stream enough beats to saturate retire_cnt
    up.in_valid = 1'b1; up.ALUResult = 32'h1;
    for (int i = 0; i < 65540; i++) tick();
    $display("saturate: retire=%0h in_ready=%0b", retire_cnt, up.in_ready);
    check("sat_retire", retire_cnt, 32'hFFFF);
    check("sat_in_ready", up.in_ready, 1);
    check("sat_taken", taken_cnt, 1);
    tick();
    check("sat_hold", retire_cnt, 32'hFFFF);

    // Reset mid-stream
    reset = 1'b0;
    tick();
    reset = 1'b1; up.in_valid = 1'b0;
    $display("mid reset: retire=%0d taken=%0d valid=%0b", retire_cnt, taken_cnt, dn.out_valid);
    check("rst2_retire", retire_cnt, 0);
    check("rst2_taken", taken_cnt, 0);
    check("rst2_valid", dn.out_valid, 0);
    check("rst2_alu", dn.out_ALUResult, 0);
    tick();
    check("rst2_stay_empty", dn.out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
